weight_dot_mac: RTL

Serial multiply-accumulate stage that consumes the 496-bit weight vector produced by the weight selection mux and computes one neuron's dot product against a 62-element activation vector. It latches both vectors on `start`, processes one term per cycle, and reports the raw 24-bit sum plus an 8-bit saturated activation. One instance serves hidden-layer neurons (62 terms) and output-layer neurons (30 terms, upper weights zero).

---
 rtl/weight_dot_mac_pkg.sv | 26 ++
 rtl/weight_dot_mac_sat_clamp.sv | 33 +++
 rtl/weight_dot_mac.sv | 103 ++++++++++
 3 files changed

// File: rtl/weight_dot_mac_pkg.sv
// Shared defaults, FSM encoding and saturation bounds for the serial dot-product MAC.
package weight_dot_mac_pkg;

  localparam int N_TERMS_D = 62;
  localparam int W_D       = 8;
  localparam int ACC_W_D   = 24;
  localparam int FRAC_D    = 7;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Clamp bounds for a W-bit result: unsigned ReLU range and signed range.
  function automatic int clamp_umax(input int w);
    return (1 << w) - 1;
  endfunction

  function automatic int clamp_smax(input int w);
    return (1 << (w - 1)) - 1;
  endfunction

  function automatic int clamp_smin(input int w);
    return -(1 << (w - 1));
  endfunction

endpackage

// File: rtl/weight_dot_mac_sat_clamp.sv
// Arithmetic shift of the accumulator followed by ReLU or signed saturation to W bits.
import weight_dot_mac_pkg::*;

module sat_clamp #(
  parameter int ACC_W = ACC_W_D,
  parameter int W     = W_D,
  parameter int FRAC  = FRAC_D
) (
  input  logic signed [ACC_W-1:0] i_acc,
  input  logic                    i_relu_en,
  output logic        [W-1:0]     o_act
);

  localparam logic signed [ACC_W-1:0] L_UMAX = ACC_W'(clamp_umax(W));
  localparam logic signed [ACC_W-1:0] L_SMAX = ACC_W'(clamp_smax(W));
  localparam logic signed [ACC_W-1:0] L_SMIN = ACC_W'(clamp_smin(W));

  logic signed [ACC_W-1:0] w_s;

  assign w_s = i_acc >>> FRAC;

  always_comb begin
    o_act = w_s[W-1:0];
    if (i_relu_en) begin
      if (w_s < 0)           o_act = '0;
      else if (w_s > L_UMAX) o_act = L_UMAX[W-1:0];
    end else begin
      if (w_s > L_SMAX)      o_act = L_SMAX[W-1:0];
      else if (w_s < L_SMIN) o_act = L_SMIN[W-1:0];
    end
  end

endmodule

// File: rtl/weight_dot_mac.sv
// One-term-per-cycle signed-weight x unsigned-activation dot product with saturated activation output.
import weight_dot_mac_pkg::*;

module weight_dot_mac #(
  parameter int N_TERMS = N_TERMS_D,
  parameter int W       = W_D,
  parameter int ACC_W   = ACC_W_D,
  parameter int FRAC    = FRAC_D
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [N_TERMS*W-1:0]    weight_i,
  input  logic [N_TERMS*W-1:0]    act_i,
  input  logic [5:0]              len_i,
  input  logic                    relu_en,
  output logic                    busy,
  output logic                    done,
  output logic signed [ACC_W-1:0] sum_o,
  output logic [W-1:0]            act_o
);

  localparam int PW = 2*W + 1;

  logic [1:0]                  r_state;
  logic [N_TERMS-1:0][W-1:0]   r_w;
  logic [N_TERMS-1:0][W-1:0]   r_a;
  logic [5:0]                  r_cnt;
  logic [5:0]                  r_n;
  logic                        r_relu;
  logic signed [ACC_W-1:0]     r_acc;
  logic signed [ACC_W-1:0]     r_sum;
  logic [W-1:0]                r_act;

  logic                        w_accept;
  logic                        w_last;
  logic [5:0]                  w_len_eff;
  logic signed [PW-1:0]        w_prod;
  logic signed [ACC_W-1:0]     w_acc_nxt;
  logic [W-1:0]                w_clamp;

  assign w_accept  = start && (r_state == ST_IDLE || r_state == ST_DONE);
  assign w_len_eff = (len_i == 6'd0 || len_i > 6'(N_TERMS)) ? 6'(N_TERMS) : len_i;
  assign w_last    = (r_cnt == r_n - 6'd1);

  // Zero-extending the activation keeps it positive in the signed multiply.
  assign w_prod    = $signed(r_w[0]) * $signed({1'b0, r_a[0]});
  assign w_acc_nxt = r_acc + {{(ACC_W-PW){w_prod[PW-1]}}, w_prod};

  sat_clamp #(.ACC_W(ACC_W), .W(W), .FRAC(FRAC)) u_clamp (
    .i_acc     (w_acc_nxt),
    .i_relu_en (r_relu),
    .o_act     (w_clamp)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_w     <= '0;
      r_a     <= '0;
      r_cnt   <= '0;
      r_n     <= '0;
      r_relu  <= 1'b0;
      r_acc   <= '0;
      r_sum   <= '0;
      r_act   <= '0;
    end else begin
      case (r_state)
        ST_RUN: begin
          r_acc <= w_acc_nxt;
          r_w   <= {{W{1'b0}}, r_w[N_TERMS-1:1]};
          r_a   <= {{W{1'b0}}, r_a[N_TERMS-1:1]};
          r_cnt <= r_cnt + 6'd1;
          if (w_last) begin
            r_state <= ST_DONE;
            r_sum   <= w_acc_nxt;
            r_act   <= w_clamp;
          end
        end
        default: begin
          // IDLE and DONE both accept; DONE falls back to IDLE otherwise.
          if (w_accept) begin
            r_state <= ST_RUN;
            r_w     <= weight_i;
            r_a     <= act_i;
            r_cnt   <= '0;
            r_n     <= w_len_eff;
            r_relu  <= relu_en;
            r_acc   <= '0;
          end else begin
            r_state <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign busy  = (r_state == ST_RUN);
  assign done  = (r_state == ST_DONE);
  assign sum_o = r_sum;
  assign act_o = r_act;

endmodule
